// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage_pkg
// Description : Shared definitions for the instruction fetch stage: data
//               width, the NOP used for bubbles, the fetch FSM state type and
//               the {pc, instr} prefetch buffer entry.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_stage_pkg;

   localparam int DATA_WIDTH = 32;

   // addi x0, x0, 0
   localparam logic [DATA_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [0:0] {
      FETCH = 1'b0,
      DRAIN = 1'b1
   } fetch_state_e;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] pc;
      logic [DATA_WIDTH-1:0] instr;
   } fetch_entry_t;

endpackage : fetch_stage_pkg
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_buffer
// Description : Synchronous FIFO of {pc, instr} prefetch entries.
//   clk, rst      : clock and synchronous active-high reset
//   flush_i       : empty the FIFO (wins over push/pop)
//   push_i/entry  : write an entry (ignored when full)
//   pop_i         : drop the head entry (ignored when empty)
//   head_o        : current head entry
//   count_o, empty_o, full_o : occupancy status
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_buffer
   import fetch_stage_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush_i,
   input  logic             push_i,
   input  fetch_entry_t     push_entry_i,
   input  logic             pop_i,
   output fetch_entry_t     head_o,
   output logic [CNT_W-1:0] count_o,
   output logic             empty_o,
   output logic             full_o
);

   fetch_entry_t     mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

   always_comb begin
      do_push  = push_i && !full_o && !flush_i;
      do_pop   = pop_i && !empty_o && !flush_i;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         // DEPTH is a power of two, so pointers wrap naturally
         if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: count_q gates every read of it
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_entry_i;
   end

endmodule : fetch_buffer
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction fetch stage with credit-limited prefetch, a
//               bypassable prefetch buffer, IF/ID output register, and
//               redirect handling that drains stale in-flight responses.
//   imem_req_*  : request channel (valid/ready, address)
//   imem_rsp_*  : in-order response channel (valid, data)
//   ID_stall_i  : hold IF/ID outputs
//   redirect_*  : taken branch / jump target from downstream
//   ID_*_o      : IF/ID register outputs to decode
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [DATA_WIDTH-1:0] RESET_PC  = 32'h0000_0000,
   parameter int                    BUF_DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  imem_req_valid_o,
   input  logic                  imem_req_ready_i,
   output logic [DATA_WIDTH-1:0] imem_addr_o,
   input  logic                  imem_rsp_valid_i,
   input  logic [DATA_WIDTH-1:0] imem_rsp_data_i,
   input  logic                  ID_stall_i,
   input  logic                  redirect_valid_i,
   input  logic [DATA_WIDTH-1:0] redirect_pc_i,
   output logic                  ID_valid_o,
   output logic [DATA_WIDTH-1:0] ID_instruction_o,
   output logic [DATA_WIDTH-1:0] ID_pc_o,
   output logic [DATA_WIDTH-1:0] ID_pc_plus4_o
);

   localparam int               CNT_W        = $clog2(BUF_DEPTH) + 1;
   localparam logic [CNT_W:0]   CREDIT_LIMIT = (CNT_W + 1)'(BUF_DEPTH);

   fetch_state_e          state_q, state_d;
   logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
   logic [DATA_WIDTH-1:0] rsp_pc_q, rsp_pc_d;
   logic [CNT_W-1:0]      outstanding_q, outstanding_d;
   logic [CNT_W-1:0]      drop_cnt_q, drop_cnt_d;
   logic                  id_valid_q, id_valid_d;
   logic [DATA_WIDTH-1:0] id_instr_q, id_instr_d;
   logic [DATA_WIDTH-1:0] id_pc_q, id_pc_d;
   logic [DATA_WIDTH-1:0] id_pc_plus4_q, id_pc_plus4_d;

   logic                  buf_push, buf_pop, buf_flush;
   fetch_entry_t          buf_push_entry, buf_head;
   logic [CNT_W-1:0]      buf_count;
   logic                  buf_empty, buf_full;

   logic                  credit_ok, req_valid, req_fire, rsp_fire, rsp_keep;

   fetch_buffer #(.DEPTH(BUF_DEPTH)) u_fetch_buffer (
      .clk          (clk),
      .rst          (rst),
      .flush_i      (buf_flush),
      .push_i       (buf_push),
      .push_entry_i (buf_push_entry),
      .pop_i        (buf_pop),
      .head_o       (buf_head),
      .count_o      (buf_count),
      .empty_o      (buf_empty),
      .full_o       (buf_full)
   );

   always_comb begin
      // Every outstanding request owns a buffer slot, so the buffer never overflows
      credit_ok = !buf_full &&
                  (({1'b0, outstanding_q} + {1'b0, buf_count}) < CREDIT_LIMIT);
      req_valid = !rst && (state_q == FETCH) && !redirect_valid_i && credit_ok;
      req_fire  = req_valid && imem_req_ready_i;
      rsp_fire  = imem_rsp_valid_i && (outstanding_q != '0);
      // A response landing with a redirect belongs to the old path
      rsp_keep  = rsp_fire && (state_q == FETCH) && !redirect_valid_i;

      state_d        = state_q;
      fetch_pc_d     = fetch_pc_q;
      rsp_pc_d       = rsp_pc_q;
      drop_cnt_d     = drop_cnt_q;
      id_valid_d     = id_valid_q;
      id_instr_d     = id_instr_q;
      id_pc_d        = id_pc_q;
      id_pc_plus4_d  = id_pc_plus4_q;
      buf_push       = 1'b0;
      buf_pop        = 1'b0;
      buf_flush      = 1'b0;
      buf_push_entry = '{pc: rsp_pc_q, instr: imem_rsp_data_i};

      outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(rsp_fire);
      if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
      if (rsp_keep) rsp_pc_d   = rsp_pc_q + 32'd4;

      if (redirect_valid_i) begin
         fetch_pc_d = redirect_pc_i;
         rsp_pc_d   = redirect_pc_i;
         buf_flush  = 1'b1;
         id_valid_d = 1'b0;
         id_instr_d = NOP_INSTR;
         // Everything still in flight after this cycle is on the old path
         drop_cnt_d = outstanding_d;
         state_d    = (outstanding_d != '0) ? DRAIN : FETCH;
      end else begin
         if ((state_q == DRAIN) && rsp_fire) begin
            drop_cnt_d = drop_cnt_q - CNT_W'(1);
            if (drop_cnt_q == CNT_W'(1)) state_d = FETCH;
         end
         if (!ID_stall_i) begin
            if (!buf_empty) begin
               buf_pop       = 1'b1;
               buf_push      = rsp_keep;
               id_valid_d    = 1'b1;
               id_instr_d    = buf_head.instr;
               id_pc_d       = buf_head.pc;
               id_pc_plus4_d = buf_head.pc + 32'd4;
            end else if (rsp_keep) begin
               id_valid_d    = 1'b1;
               id_instr_d    = imem_rsp_data_i;
               id_pc_d       = rsp_pc_q;
               id_pc_plus4_d = rsp_pc_q + 32'd4;
            end else begin
               id_valid_d = 1'b0;
               id_instr_d = NOP_INSTR;
            end
         end else begin
            buf_push = rsp_keep;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= FETCH;
         fetch_pc_q    <= RESET_PC;
         rsp_pc_q      <= RESET_PC;
         outstanding_q <= '0;
         drop_cnt_q    <= '0;
         id_valid_q    <= 1'b0;
         id_instr_q    <= NOP_INSTR;
         id_pc_q       <= '0;
         id_pc_plus4_q <= 32'd4;
      end else begin
         state_q       <= state_d;
         fetch_pc_q    <= fetch_pc_d;
         rsp_pc_q      <= rsp_pc_d;
         outstanding_q <= outstanding_d;
         drop_cnt_q    <= drop_cnt_d;
         id_valid_q    <= id_valid_d;
         id_instr_q    <= id_instr_d;
         id_pc_q       <= id_pc_d;
         id_pc_plus4_q <= id_pc_plus4_d;
      end
   end

   assign imem_req_valid_o = req_valid;
   assign imem_addr_o      = fetch_pc_q;
   assign ID_valid_o       = id_valid_q;
   assign ID_instruction_o = id_instr_q;
   assign ID_pc_o          = id_pc_q;
   assign ID_pc_plus4_o    = id_pc_plus4_q;

endmodule : fetch_stage
`default_nettype wire

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter BUF_DEPTH, default 2, meaning the number of prefetch buffer entries and the maximum number of outstanding fetches; legal values are powers of two, minimum 2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port imem_req_valid_o, output, 1 bit: fetch request valid.
REQ-006 SHALL have port imem_req_ready_i, input, 1 bit: memory accepts the request.
REQ-007 SHALL have port imem_addr_o, output, DATA_WIDTH bits: fetch address.
REQ-008 SHALL have port imem_rsp_valid_i, input, 1 bit: response data valid.
REQ-009 SHALL have port imem_rsp_data_i, input, DATA_WIDTH bits: instruction word.
REQ-010 SHALL have port ID_stall_i, input, 1 bit: hold the IF/ID outputs (load-use hazard).
REQ-011 SHALL have port redirect_valid_i, input, 1 bit: taken branch or jump resolved downstream.
REQ-012 SHALL have port redirect_pc_i, input, DATA_WIDTH bits: redirect target.
REQ-013 SHALL have port ID_valid_o, output, 1 bit: ID_instruction_o holds a real instruction.
REQ-014 SHALL have port ID_instruction_o, output, DATA_WIDTH bits: instruction presented to decode.
REQ-015 SHALL have port ID_pc_o, output, DATA_WIDTH bits: PC of ID_instruction_o.
REQ-016 SHALL have port ID_pc_plus4_o, output, DATA_WIDTH bits: ID_pc_o + 4.

Function
REQ-017 SHALL track the request issue point with register fetch_pc; imem_addr_o = fetch_pc; an accepted request (valid && ready) adds 4, with modulo-2^32 wrap.
REQ-018 SHALL assert imem_req_valid_o only in FETCH, and only while outstanding + buf_count < BUF_DEPTH; the buffer therefore never overflows.
REQ-019 SHALL track the response PC with register rsp_pc; each kept response is pushed as {rsp_pc, data} and rsp_pc then increments by 4.
REQ-020 SHALL move one entry per cycle into IF/ID when ID_stall_i = 0: the buffer head if the buffer is non-empty, otherwise a same-cycle kept response (bypass, 1-cycle latency), otherwise a bubble.
REQ-021 SHALL present a bubble as ID_valid_o = 0 and ID_instruction_o = NOP_INSTR (32'h0000_0013), with the PC outputs holding their previous values.
REQ-022 SHALL hold all IF/ID outputs and leave the buffer unpopped while ID_stall_i = 1; responses still push, and requests still issue if credits allow.
REQ-023 SHALL implement FSM states FETCH and DRAIN.
REQ-024 SHALL handle redirect_valid_i = 1 in any state as follows:
- fetch_pc <= redirect_pc_i and rsp_pc <= redirect_pc_i;
- flush the buffer;
- make IF/ID a bubble, overriding ID_stall_i;
- drop_cnt <= number of requests outstanding after this cycle;
- go to DRAIN if drop_cnt is non-zero, else FETCH;
- suppress imem_req_valid_o in that cycle.
REQ-025 SHALL, in DRAIN, discard each response and decrement drop_cnt; the response that decrements drop_cnt to 0 is also discarded, and the FSM then enters FETCH on the next cycle.
REQ-026 SHALL count a response arriving in the same cycle as a redirect as stale, so it is discarded.

Reset
REQ-027 SHALL, while rst = 1, reset the following state: fetch_pc = rsp_pc = RESET_PC; FSM = FETCH; buffer empty; outstanding = 0; drop_cnt = 0.
REQ-028 SHALL, while rst = 1, drive ID_valid_o = 0, ID_instruction_o = NOP_INSTR, ID_pc_o = 0, ID_pc_plus4_o = 4, and imem_req_valid_o = 0.
REQ-029 SHALL ignore responses to requests issued before a reset; the environment guarantees none arrive after rst deasserts.

Structure
REQ-030 SHALL place NOP_INSTR and the typedef fetch_state_e {FETCH, DRAIN} in the shared defines package.
REQ-031 SHALL implement the prefetch buffer as sub-module fetch_buffer: a synchronous FIFO of {pc, instr} entries with push, pop, flush, count, empty and full.

Verification
REQ-032 SHALL cover reset release with ready = 1 and 1-cycle response latency -> addresses 0, 4, 8 in consecutive cycles; ID_pc_o 0, 4, 8 with ID_valid_o = 1, the first valid one cycle after the first response.
REQ-033 SHALL cover ID_stall_i held high for 4 cycles -> ID outputs frozen; at most BUF_DEPTH requests outstanding plus buffered; after release the PCs continue without gap or duplicate.
REQ-034 SHALL cover redirect to 32'h100 with 2 requests outstanding -> the next 2 responses are dropped, one bubble follows, the first valid ID_pc_o is 32'h100, and ID_pc_plus4_o is 32'h104.
REQ-035 SHALL cover redirect to 32'h200 in the same cycle as a response and ID_stall_i = 1 -> the response is discarded, IF/ID becomes a bubble, and the next valid PC is 32'h200.
REQ-036 SHALL cover fetch_pc = 32'hFFFF_FFFC -> the next request address is 32'h0000_0000 and ID_pc_plus4_o wraps to 0.
REQ-037 SHALL cover rst asserted during DRAIN -> the next cycle shows reset values, and the first request after release is at RESET_PC.
